// File: rtl/status_reg.sv
// status_reg: 6502 processor status (P) register, push-byte formation, IRQ masking and NMI edge capture.
// Build option STATUS_DECIMAL_EN: when defined flag_d reflects stored D; otherwise flag_d reads 0 (2A03-style).
module status_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_co,
  input  logic       upd_en,
  input  logic [5:0] upd_mask,
  input  logic [1:0] upd_src,
  input  logic [7:0] data_in,
  input  logic       push_brk,
  input  logic       sync,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_d,
  output logic       flag_i,
  output logic       flag_z,
  output logic       flag_c,
  output logic [7:0] p_out,
  output logic       irq_mask,
  output logic       int_irq,
  output logic       int_nmi
);

  localparam int unsigned FLAG_W = 6;
  localparam logic [FLAG_W-1:0] FLAGS_RST = 6'b000100;
  localparam logic [FLAG_W-1:0] ALU_FLAGS = 6'b110011;
  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_BUS = 1;
  localparam int unsigned SRC_SET = 2;

  // Flag vector order {N,V,D,I,Z,C}
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] src_vec;
  logic [FLAG_W-1:0] eff_mask;
  logic              nmi_q;
  logic              nmi_pend;
  logic              nmi_edge;
  logic              unused_bus_bits;

  assign unused_bus_bits = ^data_in[5:4];

  // Select update source and merge under the effective mask
  always_comb begin
    src_vec  = '0;
    eff_mask = '0;
    flags_d  = flags_q;
    unique case (upd_src)
      2'(SRC_ALU): src_vec = {alu_n, alu_v, 1'b0, 1'b0, alu_z, alu_co};
      2'(SRC_BUS): src_vec = {data_in[7:6], data_in[3:0]};
      2'(SRC_SET): src_vec = '1;
      default:     src_vec = '0;
    endcase
    if (upd_en) begin
      // The ALU has no D/I outputs, so those bits hold under the ALU source
      eff_mask = (upd_src == 2'(SRC_ALU)) ? (upd_mask & ALU_FLAGS) : upd_mask;
    end
    flags_d = (flags_q & ~eff_mask) | (src_vec & eff_mask);
  end

  assign nmi_edge = nmi_q & ~nmi_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= FLAGS_RST;
      irq_mask <= 1'b1;
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      flags_q <= flags_d;
      // Sampling pre-update I at the boundary gives the NMOS one-instruction delay
      if (sync) irq_mask <= flags_q[2];
      nmi_q <= nmi_n;
      if (nmi_edge) nmi_pend <= 1'b1;
      else if (nmi_ack) nmi_pend <= 1'b0;
    end
  end

  assign flag_n = flags_q[5];
  assign flag_v = flags_q[4];
`ifdef STATUS_DECIMAL_EN
  assign flag_d = flags_q[3];
`else
  assign flag_d = 1'b0;
`endif
  assign flag_i = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_c = flags_q[0];

  assign p_out   = {flags_q[5:4], 1'b1, push_brk, flags_q[3:0]};
  assign int_irq = ~irq_n & ~irq_mask;
  assign int_nmi = nmi_pend;

endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed plus randomized checks of status_reg against a byte-level model of P.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alu_n = 1'b0, alu_v = 1'b0, alu_z = 1'b0, alu_co = 1'b0;
  logic       upd_en = 1'b0;
  logic [5:0] upd_mask = '0;
  logic [1:0] upd_src = '0;
  logic [7:0] data_in = '0;
  logic       push_brk = 1'b0;
  logic       sync = 1'b0;
  logic       irq_n = 1'b1;
  logic       nmi_n = 1'b1;
  logic       nmi_ack = 1'b0;
  logic       flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
  logic [7:0] p_out;
  logic       irq_mask, int_irq, int_nmi;

  int checks = 0;
  int failures = 0;

  // Model: P kept as a byte in bus layout; bits 5/4 stay 0 in storage
  logic [7:0] mp;
  logic       m_mask, m_pend, m_prev;

`ifdef STATUS_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  status_reg dut (
    .clk(clk), .reset(reset),
    .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_co(alu_co),
    .upd_en(upd_en), .upd_mask(upd_mask), .upd_src(upd_src), .data_in(data_in),
    .push_brk(push_brk), .sync(sync), .irq_n(irq_n), .nmi_n(nmi_n), .nmi_ack(nmi_ack),
    .flag_n(flag_n), .flag_v(flag_v), .flag_d(flag_d), .flag_i(flag_i),
    .flag_z(flag_z), .flag_c(flag_c), .p_out(p_out),
    .irq_mask(irq_mask), .int_irq(int_irq), .int_nmi(int_nmi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare everything
  task automatic tick();
    logic [7:0] mb, src, exp_p;
    logic [5:0] exp_f;
    @(posedge clk);
    if (reset) begin
      mp = 8'h04; m_mask = 1'b1; m_pend = 1'b0; m_prev = 1'b1;
    end else begin
      if (sync) m_mask = mp[2];
      if (upd_en) begin
        mb = {upd_mask[5:4], 2'b00, upd_mask[3:0]};
        case (upd_src)
          2'd0: begin src = {alu_n, alu_v, 4'b0000, alu_z, alu_co}; mb = mb & 8'hC3; end
          2'd1: src = data_in;
          2'd2: src = 8'hFF;
          default: src = 8'h00;
        endcase
        mp = (mp & ~mb) | (src & mb);
      end
      if (m_prev && !nmi_n) m_pend = 1'b1;
      else if (nmi_ack) m_pend = 1'b0;
      m_prev = nmi_n;
    end
    #1;
    exp_p = {mp[7:6], 1'b1, push_brk, mp[3:0]};
    exp_f = {mp[7], mp[6], mp[3] & DEC_EN, mp[2], mp[1], mp[0]};
    chk("p_out", p_out, exp_p);
    chk("flags", {2'b00, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c}, {2'b00, exp_f});
    chk("irq_mask", {7'd0, irq_mask}, {7'd0, m_mask});
    chk("int_irq", {7'd0, int_irq}, {7'd0, ~irq_n & ~m_mask});
    chk("int_nmi", {7'd0, int_nmi}, {7'd0, m_pend});
  endtask

  task automatic upd(input logic [1:0] src, input logic [5:0] mask);
    upd_en = 1'b1; upd_src = src; upd_mask = mask;
  endtask

  initial begin
    // Reset with a competing bus update held
    reset = 1'b1; data_in = 8'hFF; upd(2'd1, 6'h3F); sync = 1'b1;
    tick(); tick();
    chk("reset_p", p_out, 8'h24);
    chk("reset_mask", {7'd0, irq_mask}, 8'h01);
    chk("reset_nmi", {7'd0, int_nmi}, 8'h00);
    reset = 1'b0; upd_en = 1'b0; sync = 1'b0;
    tick();
    chk("idle_p", p_out, 8'h24);

    // ALU update
    alu_n = 1'b1; alu_v = 1'b1; alu_z = 1'b0; alu_co = 1'b1; upd(2'd0, 6'b110011);
    tick();
    chk("alu_p", p_out, 8'hE5);
    alu_z = 1'b1; upd(2'd0, 6'b000010);
    tick();
    chk("alu_z_p", p_out, 8'hE7);

    // PLP
    data_in = 8'hFF; upd(2'd1, 6'h3F); push_brk = 1'b1;
    tick();
    chk("plp_ff", p_out, 8'hFF);
    data_in = 8'h00;
    tick();
    chk("plp_00", p_out, 8'h30);
    upd_en = 1'b0; push_brk = 1'b0;

    // SEI and latch it into the mask, then CLI with one-instruction latency
    upd(2'd2, 6'b000100); tick();
    upd_en = 1'b0; sync = 1'b1; tick();
    chk("sei_mask", {7'd0, irq_mask}, 8'h01);
    irq_n = 1'b0; upd(2'd3, 6'b000100); sync = 1'b1;
    tick();
    chk("cli_same_sync", {7'd0, int_irq}, 8'h00);
    upd_en = 1'b0; sync = 1'b0; tick();
    chk("cli_wait", {7'd0, int_irq}, 8'h00);
    sync = 1'b1; tick();
    chk("cli_taken", {7'd0, int_irq}, 8'h01);
    sync = 1'b0; irq_n = 1'b1;

    // NMI: single edge, held low, ack, re-edge with ack
    nmi_n = 1'b0; tick();
    chk("nmi_rise", {7'd0, int_nmi}, 8'h01);
    for (int k = 0; k < 9; k++) tick();
    nmi_ack = 1'b1; tick();
    chk("nmi_ack", {7'd0, int_nmi}, 8'h00);
    nmi_ack = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("nmi_no_retrig", {7'd0, int_nmi}, 8'h00);
    nmi_n = 1'b1; tick();
    nmi_n = 1'b0; tick();
    nmi_n = 1'b1; tick();
    nmi_n = 1'b0; nmi_ack = 1'b1; tick();
    chk("nmi_set_wins", {7'd0, int_nmi}, 8'h01);
    nmi_ack = 1'b0;

    // SED: stored D always visible on p_out[3]; flag_d only with the decimal option
    upd(2'd2, 6'b001000); tick();
    upd_en = 1'b0;
    chk("sed_p3", {7'd0, p_out[3]}, 8'h01);
    chk("sed_flag_d", {7'd0, flag_d}, {7'd0, DEC_EN});

    // nmi_n low through reset registers one edge after release
    nmi_n = 1'b0; reset = 1'b1; tick();
    chk("nmi_in_reset", {7'd0, int_nmi}, 8'h00);
    reset = 1'b0; tick();
    chk("nmi_post_reset", {7'd0, int_nmi}, 8'h01);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      reset    = ($urandom_range(0, 60) == 0);
      alu_n    = 1'($urandom); alu_v = 1'($urandom);
      alu_z    = 1'($urandom); alu_co = 1'($urandom);
      upd_en   = 1'($urandom);
      upd_mask = 6'($urandom);
      upd_src  = 2'($urandom);
      data_in  = 8'($urandom);
      push_brk = 1'($urandom);
      sync     = ($urandom_range(0, 2) == 0);
      irq_n    = 1'($urandom);
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      nmi_ack  = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_reg.md
# status_reg

Processor status (P) register for the MOS 6502 core. It is the consumer end of the ALU flag interface: it latches the ALU's N/V/Z/CO outputs under per-flag update masks, loads P from the data bus for PLP/RTI/BIT, and applies SEx/CLx constants. It also forms the push byte for PHP/BRK/IRQ/NMI, and provides instruction-boundary interrupt masking plus NMI edge capture. It sits between the ALU and the control/sequencer logic.

## Interface
Parameters: none.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- alu_n  input  1  ALU N output
- alu_v  input  1  ALU V output
- alu_z  input  1  ALU Z output
- alu_co  input  1  ALU CO output
- upd_en  input  1  apply flag update this cycle
- upd_mask  input  6  flags to update, bit order {N,V,D,I,Z,C} = [5:0]
- upd_src  input  2  00 ALU, 01 data_in, 10 set to 1, 11 clear to 0
- data_in  input  8  bus byte in P layout (bits 7,6,3,2,1,0 = N,V,D,I,Z,C)
- push_brk  input  1  value driven on bit 4 of p_out
- sync  input  1  opcode-fetch cycle (instruction boundary)
- irq_n  input  1  level IRQ, active-low
- nmi_n  input  1  NMI, active-low, falling-edge sensitive
- nmi_ack  input  1  sequencer has taken the pending NMI
- flag_n, flag_v, flag_d, flag_i, flag_z, flag_c  output  1 each  current flags
- p_out  output  8  push byte {N,V,1,push_brk,D,I,Z,C}
- irq_mask  output  1  I value sampled at last boundary
- int_irq  output  1  IRQ request visible to sequencer
- int_nmi  output  1  NMI pending

## Operation
- Update, when upd_en=1, applies to each flag whose upd_mask bit is 1; unmasked flags hold.
- upd_src=00 (ALU): N<=alu_n, V<=alu_v, Z<=alu_z, C<=alu_co. A masked D or I with this source holds; the sequencer never issues that combination.
- upd_src=01 (bus): each masked flag <= the corresponding data_in bit. data_in bits 5 and 4 are ignored. This source serves PLP/RTI (mask 6'b111111) and BIT (mask 6'b110000).
- upd_src=10/11: each masked flag <= 1/0. This source serves SEC/CLC/SEI/CLI/SED/CLD/CLV.
- p_out is combinational from the registered flags; bit 5 is always 1 and bit 4 = push_brk.
- Interrupt mask:
  - irq_mask <= flag_i on every cycle with sync=1; it holds otherwise.
  - As a result, CLI/SEI/PLP take effect one instruction late, as on the NMOS part.
- int_irq = !irq_n & !irq_mask (combinational).
- NMI edge detector:
  - nmi_q <= nmi_n every cycle.
  - A falling edge is detected when nmi_q=1 and nmi_n=0; it sets nmi_pend.
  - nmi_ack=1 clears nmi_pend.
  - If an edge and nmi_ack occur in the same cycle, the set wins.
- int_nmi = nmi_pend.
- A held-low nmi_n produces exactly one pending NMI.

## Timing
- Flag updates become visible on the flag outputs and p_out one cycle after the upd_en edge.
- irq_mask follows flag_i at the first sync cycle after the flag changes.
- If upd_en and sync are asserted in the same cycle, irq_mask samples the pre-update flag_i.
- NMI latency: int_nmi rises in the cycle after the first cycle where nmi_n is sampled low.
- Reset values, effective on the first edge with reset=1:
  - N=V=D=Z=C=0, I=1
  - irq_mask=1
  - nmi_pend=0
  - nmi_q=1
- Reset overrides upd_en, sync, nmi_ack and any edge in the same cycle.
- An NMI edge arriving during reset is discarded. Because nmi_q resets to 1, nmi_n held low through the end of reset registers one edge on the first cycle out of reset.
- No multi-cycle state: every input is acted on in the cycle it is presented.

## Configuration
- STATUS_DECIMAL_EN defined: D is fully writable through upd_src 01/10/11. flag_d and p_out[3] reflect the stored D.
- STATUS_DECIMAL_EN undefined (2A03-style, no BCD):
  - D remains a stored bit, so PLP/PHP round-trip it, and SED/CLD still write it.
  - flag_d is forced to 0, so the ALU never enters decimal mode.
  - p_out[3] still reflects the stored bit.

## Test plan
- Reset with data_in=8'hFF and upd_en=1 held -> after release, p_out=8'h24 (push_brk=0), irq_mask=1, int_nmi=0.
- ALU update: alu_n=1, alu_v=1, alu_z=0, alu_co=1, upd_src=00, mask=6'b110011 -> next cycle p_out=8'hE5 with I still 1. Then mask=6'b000010 with alu_z=1 -> p_out=8'hE7.
- PLP: data_in=8'hFF, upd_src=01, mask=6'b111111, push_brk=1 -> p_out=8'hFF. Then data_in=8'h00 -> p_out=8'h30.
- CLI latency: irq_n=0, CLI (upd_src=11, mask=6'b000100), sync pulses on the next two boundaries -> int_irq stays 0 until the first post-CLI sync edge, then reads 1.
- NMI: nmi_n falls and is held low 10 cycles -> int_nmi=1 one cycle after the fall. nmi_ack for 1 cycle -> int_nmi=0 with no re-trigger while low. nmi_n rises then falls again in the same cycle as nmi_ack -> int_nmi stays 1.
- Without STATUS_DECIMAL_EN: SED (upd_src=10, mask=6'b001000) -> flag_d=0 and p_out[3]=1. With the macro defined, the same stimulus gives flag_d=1.
